// File: rtl/wb_reg_file_if.sv
// Bus bundle between the MEM/WB and ID pipeline stages and the register file.
// The master side drives writeback and read addresses, and the slave side returns data.
interface wb_reg_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [1:0]        WB_i;
  logic [DATA_W-1:0] FUresult_i;
  logic [DATA_W-1:0] memReadData_i;
  logic [ADDR_W-1:0] RDaddr_i;
  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic [DATA_W-1:0] WBdata_o;
  logic [DATA_W-1:0] wbCount_o;

  modport master (
    output WB_i, FUresult_i, memReadData_i, RDaddr_i, RSaddr_i, RTaddr_i,
    input  RSdata_o, RTdata_o, WBdata_o, wbCount_o
  );

  modport slave (
    input  WB_i, FUresult_i, memReadData_i, RDaddr_i, RSaddr_i, RTaddr_i,
    output RSdata_o, RTdata_o, WBdata_o, wbCount_o
  );
endinterface

// File: rtl/wb_reg_file.sv
// Pipeline register file with a hardwired-zero r0, a writeback mux, same-cycle write-to-read
// bypass on both read ports, and a wrapping counter of register-write cycles.
module wb_reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic          clk_i,
  input  logic          rst_n,
  wb_reg_file_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] reg_file_reg [NREG];
  logic [DATA_W-1:0] wb_count_reg;
  logic [DATA_W-1:0] wb_count_next;
  logic [DATA_W-1:0] wb_data;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign wb_data       = bus.WB_i[1] ? bus.memReadData_i : bus.FUresult_i;
  assign wr_en         = bus.WB_i[0] && (bus.RDaddr_i != '0);
  assign wb_count_next = bus.WB_i[0] ? wb_count_reg + 1'b1 : wb_count_reg;

  // Entry 0 is only ever cleared, so it always holds zero.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        reg_file_reg[i] <= '0;
      end
      wb_count_reg <= '0;
    end else begin
      if (wr_en) begin
        reg_file_reg[bus.RDaddr_i] <= wb_data;
      end
      wb_count_reg <= wb_count_next;
    end
  end

  assign rd_addr[0] = bus.RSaddr_i;
  assign rd_addr[1] = bus.RTaddr_i;

  // During reset the bypass is masked, so the read ports are forced to zero.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
      assign rd_data[gi] = (!rst_n || rd_addr[gi] == '0)          ? '0      :
                           (wr_en && rd_addr[gi] == bus.RDaddr_i) ? wb_data :
                                                                    reg_file_reg[rd_addr[gi]];
    end
  endgenerate

  assign bus.RSdata_o  = rd_data[0];
  assign bus.RTdata_o  = rd_data[1];
  assign bus.WBdata_o  = wb_data;
  assign bus.wbCount_o = wb_count_reg;
endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file. Expected values are queued when a step is driven,
// then popped and compared against the outputs away from the clock edge.
module tb_wb_reg_file;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sb[$];
  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_count   = '0;

  task automatic push(input string tag, input logic [DW-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [DW-1:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL sb_underflow observed=%h required=queued entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [AW-1:0] rd,
                       input logic [DW-1:0] fu, input logic [DW-1:0] mem,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    bus.WB_i          = wb;
    bus.RDaddr_i      = rd;
    bus.FUresult_i    = fu;
    bus.memReadData_i = mem;
    bus.RSaddr_i      = rs;
    bus.RTaddr_i      = rt;
  endtask

  // Advance one clock edge; the expected count follows the stimulus just applied.
  task automatic tick();
    @(posedge clk);
    if (rst_n && bus.WB_i[0]) exp_count = exp_count + 1'b1;
    #1;
  endtask

  task automatic check_ports(input string tag, input logic [DW-1:0] rs_exp,
                             input logic [DW-1:0] rt_exp);
    push({tag, "_rs"}, rs_exp);
    push({tag, "_rt"}, rt_exp);
    pop_check(bus.RSdata_o);
    pop_check(bus.RTdata_o);
  endtask

  task automatic check_count(input string tag);
    push({tag, "_cnt"}, exp_count);
    pop_check(bus.wbCount_o);
  endtask

  initial begin
    // Reset, then read every address on both ports
    rst_n = 1'b0;
    drive(2'b00, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0);
    #2;
    check_count("rst");
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int a = 0; a < 8; a++) begin
      drive(2'b00, 3'd0, 16'h0, 16'h0, 3'(a), 3'(7 - a));
      #1;
      check_ports($sformatf("rst_read%0d", a), 16'h0000, 16'h0000);
    end
    check_count("rst_read");

    // Writeback from FU result, then from memory data
    tick();
    drive(2'b01, 3'd3, 16'h1234, 16'h9999, 3'd0, 3'd0);
    #1;
    push("mux_fu_wbdata", 16'h1234);
    pop_check(bus.WBdata_o);
    tick();
    drive(2'b11, 3'd5, 16'h7777, 16'hBEEF, 3'd0, 3'd0);
    #1;
    push("mux_mem_wbdata", 16'hBEEF);
    pop_check(bus.WBdata_o);
    tick();
    drive(2'b00, 3'd0, 16'h0, 16'h0, 3'd3, 3'd5);
    #1;
    check_ports("write_mux", 16'h1234, 16'hBEEF);
    push("write_mux_cnt2", 16'd2);
    pop_check(bus.wbCount_o);

    // r0 stays zero, but the write still counts
    drive(2'b01, 3'd0, 16'hFFFF, 16'h0, 3'd0, 3'd0);
    #1;
    check_ports("r0_same", 16'h0000, 16'h0000);
    tick();
    drive(2'b00, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0);
    #1;
    check_ports("r0_next", 16'h0000, 16'h0000);
    push("r0_cnt3", 16'd3);
    pop_check(bus.wbCount_o);

    // Same-cycle bypass on both ports
    drive(2'b01, 3'd4, 16'h0001, 16'h0, 3'd0, 3'd0);
    tick();
    drive(2'b00, 3'd0, 16'h0, 16'h0, 3'd4, 3'd4);
    #1;
    check_ports("reg4_stored", 16'h0001, 16'h0001);
    drive(2'b01, 3'd4, 16'h00AA, 16'h0, 3'd4, 3'd4);
    #1;
    check_ports("bypass_pre", 16'h00AA, 16'h00AA);
    tick();
    drive(2'b00, 3'd0, 16'h0, 16'h0, 3'd4, 3'd0);
    #1;
    check_ports("bypass_post", 16'h00AA, 16'h0000);

    // Write with RegWrite clear is dropped
    drive(2'b01, 3'd2, 16'h2222, 16'h0, 3'd0, 3'd0);
    tick();
    drive(2'b10, 3'd2, 16'h0, 16'h5555, 3'd2, 3'd2);
    #1;
    check_ports("nowr_pre", 16'h2222, 16'h2222);
    push("nowr_wbdata", 16'h5555);
    pop_check(bus.WBdata_o);
    check_count("nowr_pre");
    tick();
    #1;
    check_ports("nowr_post", 16'h2222, 16'h2222);
    check_count("nowr_post");

    // Counter wrap across 65536 writes from a fresh reset
    rst_n = 1'b0;
    exp_count = '0;
    #1;
    rst_n = 1'b1;
    drive(2'b01, 3'd6, 16'h6666, 16'h0, 3'd6, 3'd3);
    for (int i = 0; i < 65535; i++) tick();
    push("wrap_ffff", 16'hFFFF);
    pop_check(bus.wbCount_o);
    tick();
    push("wrap_zero", 16'h0000);
    pop_check(bus.wbCount_o);
    check_ports("wrap_regs", 16'h6666, 16'h0000);

    // Asynchronous reset between edges clears everything at once
    rst_n = 1'b0;
    exp_count = '0;
    #1;
    check_ports("async_rst", 16'h0000, 16'h0000);
    check_count("async_rst");
    push("async_rst_wbdata", 16'h6666);
    pop_check(bus.WBdata_o);
    tick();
    check_ports("rst_held", 16'h0000, 16'h0000);
    check_count("rst_held");
    #2;
    rst_n = 1'b1;
    drive(2'b01, 3'd3, 16'h3333, 16'h0, 3'd3, 3'd6);
    #1;
    check_ports("post_rst_bypass", 16'h3333, 16'h0000);
    tick();
    drive(2'b00, 3'd0, 16'h0, 16'h0, 3'd3, 3'd6);
    #1;
    check_ports("post_rst_write", 16'h3333, 16'h0000);
    push("post_rst_cnt1", 16'd1);
    pop_check(bus.wbCount_o);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover observed=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
